// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: chip-side end of the multiplexed 8-bit RTC bus.
// Synchronizes the async strobes, holds a 16-byte register file and keeps a BCD time-of-day.
module rtc_bus_responder #(
  parameter int NREG      = 16,
  parameter int DRIVE_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a_d,
  inout  wire  [7:0] ad,
  input  logic       tick_1hz,
  output logic       wr_evt,
  output logic [7:0] cur_addr
);
  localparam int AW = $clog2(NREG);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;
  state_t state_q, state_d;
  logic [1:0] cs_q, rd_q, wr_q, a_q;
  logic [7:0] ad_m_q, ad_s_q, cur_addr_q, rdata_q, cnt_q, cnt_d;
  logic       rd_p_q, wr_p_q, wr_evt_q;
  logic [7:0] regs_q [NREG];
  logic cs_s, rd_s, wr_s, a_s, in_range, wr_ok, addr_we, data_we, rd_start, hold, load, oe;
  logic [7:0] sec_n, min_n, hr_n;
  logic       c_sec, c_min;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return (v == max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  assign cs_s     = cs_q[1];
  assign rd_s     = rd_q[1];
  assign wr_s     = wr_q[1];
  assign a_s      = a_q[1];
  assign in_range = cur_addr_q[7:AW] == '0;
  // a write only counts when rd has been high on both sides of the wr edge
  assign wr_ok    = ~wr_p_q & wr_s & ~cs_s & rd_s & rd_p_q;
  assign addr_we  = wr_ok & ~a_s;
  assign data_we  = wr_ok & a_s & in_range;
  assign rd_start = rd_p_q & ~rd_s & ~cs_s & a_s & wr_s;
  assign hold     = ~rd_s & ~cs_s & wr_s;
  assign oe       = (state_q == S_DRIVE) & hold;
  assign ad       = oe ? rdata_q : 8'hzz;
  assign wr_evt   = wr_evt_q;
  assign cur_addr = cur_addr_q;
  assign c_sec    = regs_q[0] == 8'h59;
  assign c_min    = regs_q[1] == 8'h59;
  assign sec_n    = bcd_inc(regs_q[0], 8'h59);
  assign min_n    = bcd_inc(regs_q[1], 8'h59);
  assign hr_n     = bcd_inc(regs_q[2], 8'h23);
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_d   = (state_q == S_WAIT) ? cnt_q + 8'd1 : '0;
    case (state_q)
      S_IDLE:  state_d = rd_start ? S_WAIT : S_IDLE;
      S_WAIT: begin
        state_d = !hold ? S_IDLE : (cnt_q == 8'(DRIVE_DLY - 1)) ? S_DRIVE : S_WAIT;
        load    = hold & (cnt_q == 8'(DRIVE_DLY - 1));
      end
      S_DRIVE: state_d = hold ? S_DRIVE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q       <= 2'b11;
      rd_q       <= 2'b11;
      wr_q       <= 2'b11;
      a_q        <= 2'b00;
      ad_m_q     <= '0;
      ad_s_q     <= '0;
      rd_p_q     <= 1'b1;
      wr_p_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      cur_addr_q <= '0;
      wr_evt_q   <= 1'b0;
    end else begin
      cs_q       <= {cs_q[0], cs_n};
      rd_q       <= {rd_q[0], rd_n};
      wr_q       <= {wr_q[0], wr_n};
      a_q        <= {a_q[0], a_d};
      ad_m_q     <= ad;
      ad_s_q     <= ad_m_q;
      rd_p_q     <= rd_s;
      wr_p_q     <= wr_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= load ? (in_range ? regs_q[cur_addr_q[AW-1:0]] : 8'hFF) : rdata_q;
      cur_addr_q <= addr_we ? ad_s_q : cur_addr_q;
      wr_evt_q   <= data_we;
    end
  end
  // the bus write is applied after the tick so it wins; carries use the pre-write values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (tick_1hz) begin
        regs_q[0] <= sec_n;
        if (c_sec) regs_q[1] <= min_n;
        if (c_sec && c_min) regs_q[2] <= hr_n;
      end
      if (data_we) regs_q[cur_addr_q[AW-1:0]] <= ad_s_q;
    end
  end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: table vectors, hand-written corner sequences and a random run
// against a time-of-day model kept in plain integers.
module tb_rtc_bus_responder;
  logic       clk = 1'b0;
  logic       rst_n, cs_n, rd_n, wr_n, a_d, tick_1hz, tb_oe;
  logic [7:0] tb_d;
  wire  [7:0] ad;
  logic       wr_evt;
  logic [7:0] cur_addr;
  int checks = 0, errors = 0, evt_cnt = 0, evt_long = 0;
  logic evt_prev = 1'b0;
  logic [7:0] mdl [16];
  logic [7:0] mdl_addr;

  assign ad = tb_oe ? tb_d : 8'hzz;
  always #5 clk = ~clk;

  rtc_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .ad(ad), .tick_1hz(tick_1hz), .wr_evt(wr_evt), .cur_addr(cur_addr)
  );

  always @(negedge clk) begin
    evt_cnt  <= evt_cnt + (wr_evt ? 1 : 0);
    evt_long <= evt_long + ((wr_evt && evt_prev) ? 1 : 0);
    evt_prev <= wr_evt;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wd;
    bit         wr;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic phase, input logic [7:0] d, input bit with_tick);
    @(negedge clk); cs_n = 1'b0; a_d = phase; tb_d = d; tb_oe = 1'b1;
    repeat (3) @(negedge clk); wr_n = 1'b0;
    repeat (3) @(negedge clk); wr_n = 1'b1;
    if (with_tick) begin
      repeat (2) @(negedge clk); tick_1hz = 1'b1;
      @(negedge clk); tick_1hz = 1'b0;
    end
    repeat (4) @(negedge clk); cs_n = 1'b1; tb_oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_cycle(output logic [7:0] d0, output logic [7:0] d1);
    @(negedge clk); cs_n = 1'b0; a_d = 1'b1;
    repeat (3) @(negedge clk); rd_n = 1'b0;
    repeat (8) @(negedge clk); d0 = ad;
    repeat (3) @(negedge clk); d1 = ad; rd_n = 1'b1;
    repeat (4) @(negedge clk); cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    bus_cycle(1'b0, a, 1'b0);
    bus_cycle(1'b1, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] exp, input string nm);
    logic [7:0] d0, d1;
    bus_cycle(1'b0, a, 1'b0);
    read_cycle(d0, d1);
    chk(nm, d0, exp);
  endtask

  task automatic tick();
    @(negedge clk); tick_1hz = 1'b1;
    @(negedge clk); tick_1hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  // time-of-day advanced as ordinary seconds/minutes/hours counts
  task automatic mdl_tick();
    int s, m, h;
    s = b2i(mdl[0]) + 1;
    if (s == 60) begin
      s = 0;
      m = b2i(mdl[1]) + 1;
      if (m == 60) begin
        m = 0;
        h = (b2i(mdl[2]) + 1) % 24;
        mdl[2] = i2b(h);
      end
      mdl[1] = i2b(m);
    end
    mdl[0] = i2b(s);
  endtask

  initial begin
    logic [7:0] d0, d1, a, d;
    int e0, op;
    bit seen;
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a_d = 1'b0;
    tick_1hz = 1'b0; tb_oe = 1'b0; tb_d = '0;
    vt[0] = '{8'h05, 8'hA5, 1'b1, 8'hA5};
    vt[1] = '{8'h03, 8'h3C, 1'b1, 8'h3C};
    vt[2] = '{8'h0F, 8'h81, 1'b1, 8'h81};
    vt[3] = '{8'h20, 8'h77, 1'b1, 8'hFF};
    vt[4] = '{8'h23, 8'h66, 1'b1, 8'hFF};
    vt[5] = '{8'h03, 8'h00, 1'b0, 8'h3C};
    vt[6] = '{8'h05, 8'h00, 1'b0, 8'hA5};
    vt[7] = '{8'h0A, 8'h5A, 1'b1, 8'h5A};
    repeat (4) @(negedge clk);
    chk("rst_cur_addr", cur_addr, 8'h00);
    chk("rst_wr_evt", {7'd0, wr_evt}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_reg(8'h00, 8'h00, "rst_reg0");

    foreach (vt[i]) begin
      e0 = evt_cnt;
      bus_cycle(1'b0, vt[i].addr, 1'b0);
      chk($sformatf("vec%0d_cur_addr", i), cur_addr, vt[i].addr);
      if (vt[i].wr) bus_cycle(1'b1, vt[i].wd, 1'b0);
      read_cycle(d0, d1);
      chk($sformatf("vec%0d_read", i), d0, vt[i].exp);
      chk($sformatf("vec%0d_stable", i), d1, vt[i].exp);
      chk($sformatf("vec%0d_evt", i), 8'(evt_cnt - e0), (vt[i].wr && vt[i].addr < 8'h10) ? 8'd1 : 8'd0);
    end
    rd_reg(8'h00, 8'h00, "oor_reg0_untouched");

    wr_reg(8'h00, 8'h59); wr_reg(8'h01, 8'h59); wr_reg(8'h02, 8'h23);
    tick();
    rd_reg(8'h00, 8'h00, "roll_sec");
    rd_reg(8'h01, 8'h00, "roll_min");
    rd_reg(8'h02, 8'h00, "roll_hr");
    wr_reg(8'h00, 8'h09);
    tick();
    rd_reg(8'h00, 8'h10, "bcd_carry");
    wr_reg(8'h00, 8'h19);
    bus_cycle(1'b1, 8'h30, 1'b1);
    rd_reg(8'h00, 8'h30, "collide_override");
    wr_reg(8'h01, 8'h12);
    wr_reg(8'h00, 8'h59);
    bus_cycle(1'b1, 8'h30, 1'b1);
    rd_reg(8'h00, 8'h30, "collide_sec");
    rd_reg(8'h01, 8'h13, "collide_min_carry");

    bus_cycle(1'b0, 8'h05, 1'b0);
    @(negedge clk); cs_n = 1'b0; a_d = 1'b1;
    repeat (3) @(negedge clk); rd_n = 1'b0;
    @(negedge clk); rd_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ad === 8'hA5) seen = 1'b1;
    end
    chk("abort_no_drive", {7'd0, seen}, 8'h00);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);

    e0 = evt_cnt;
    @(negedge clk); cs_n = 1'b0; a_d = 1'b1; tb_d = 8'h66; tb_oe = 1'b1;
    repeat (3) @(negedge clk); rd_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk); wr_n = 1'b1;
    repeat (4) @(negedge clk); rd_n = 1'b1;
    repeat (4) @(negedge clk); cs_n = 1'b1; tb_oe = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_low_evt", 8'(evt_cnt - e0), 8'd0);
    read_cycle(d0, d1);
    chk("both_low_no_write", d0, 8'hA5);

    @(negedge clk); cs_n = 1'b0; a_d = 1'b1;
    repeat (3) @(negedge clk); rd_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("drive_before_rst", ad, 8'hA5);
    #2 rst_n = 1'b0;
    #1 chk("rst_releases_ad", {7'd0, ad === 8'hA5}, 8'h00);
    chk("rst_mid_cur_addr", cur_addr, 8'h00);
    @(negedge clk); rd_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_reg(8'h05, 8'h00, "rst_clears_reg5");

    foreach (mdl[i]) mdl[i] = 8'h00;
    mdl_addr = 8'h05;
    for (int n = 0; n < 70; n++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255))
          : ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 15));
        bus_cycle(1'b0, a, 1'b0);
        mdl_addr = a;
        chk("rnd_cur_addr", cur_addr, mdl_addr);
      end else if (op == 1) begin
        d = (mdl_addr == 8'h02) ? i2b(int'($urandom_range(0, 23)))
          : (mdl_addr < 8'h02) ? i2b(int'($urandom_range(0, 59))) : 8'($urandom);
        e0 = evt_cnt;
        bus_cycle(1'b1, d, 1'b0);
        if (mdl_addr < 8'h10) mdl[mdl_addr[3:0]] = d;
        chk("rnd_wr_evt", 8'(evt_cnt - e0), (mdl_addr < 8'h10) ? 8'd1 : 8'd0);
      end else if (op == 2) begin
        read_cycle(d0, d1);
        chk("rnd_read", d0, (mdl_addr < 8'h10) ? mdl[mdl_addr[3:0]] : 8'hFF);
      end else begin
        repeat (int'($urandom_range(1, 3))) begin
          tick();
          mdl_tick();
        end
      end
    end
    for (int r = 0; r < 3; r++) rd_reg(8'(r), mdl[r], "rnd_time_final");
    chk("wr_evt_width", 8'(evt_long), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Synthesizable responder for the multiplexed 8-bit RTC parallel bus: the chip-side end of the bus that the controller's output mux drives during init/read/write sequences.
- Decodes address and data phases from cs_n/rd_n/wr_n/a_d and holds a 16-byte register file.
- Drives read data back onto the shared ad bus and advances a BCD time-of-day from a 1 Hz tick.
- Used as an on-FPGA RTC stand-in for bring-up and as the closed-loop bench partner of the controller.

Parameters:
- NREG, 16, number of 8-bit registers; address width is log2(NREG) = 4.
- DRIVE_DLY, 2, clk cycles from synchronized rd_n fall to ad being driven.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  chip select, active low, asynchronous to clk.
- rd_n  input  1  read strobe, active low, asynchronous.
- wr_n  input  1  write strobe, active low, asynchronous.
- a_d  input  1  0 = address phase, 1 = data phase; sampled with the strobe.
- ad  inout  8  multiplexed address/data bus, tristated unless the block is driving read data.
- tick_1hz  input  1  one-clk-wide pulse that advances the time.
- wr_evt  output  1  one-clk pulse for each completed data write.
- cur_addr  output  8  last latched address (debug).

Behaviour:
- Synchronization
  - cs_n, rd_n, wr_n, a_d: 2-flop synchronizers.
  - ad: sampled through a 2-flop synchronizer.
  - Edges are detected on the synchronized strobes.
- Reset state
  - All registers 0x00.
  - cur_addr = 0x00, wr_evt = 0, ad released (oe = 0), FSM in IDLE.
  - Reset mid-transaction releases ad immediately (async).
- Address phase
  - On the wr_n rising edge with cs_n = 0 and a_d = 0, latch the synchronized ad into cur_addr.
  - The address is out of range if cur_addr[7:4] != 0.
- Data write
  - On the wr_n rising edge with cs_n = 0 and a_d = 1 and an in-range address: reg[cur_addr[3:0]] <= ad, and wr_evt pulses the next cycle.
  - An out-of-range address leaves the register file unchanged and produces no wr_evt.
- Data read
  - On the rd_n falling edge with cs_n = 0 and a_d = 1, the FSM enters WAIT.
  - After DRIVE_DLY cycles it enters DRIVE: oe = 1, ad = reg[addr], or 0xFF if out of range.
  - Read data is latched on entry to DRIVE and held stable for the whole strobe.
- FSM: IDLE -> WAIT -> DRIVE -> IDLE.
  - DRIVE exits when rd_n = 1 or cs_n = 1; oe drops in the same cycle.
  - cs_n or rd_n going high during WAIT aborts the read, returns to IDLE and never drives ad.
  - If rd_n and wr_n are both low, the bus is not driven and no write occurs.
- Time base: reg0 = seconds, reg1 = minutes, reg2 = hours, all BCD, 24 h format.
  - tick_1hz increments seconds; 0x59 wraps to 0x00 and carries to minutes.
  - Minutes wrap 0x59 -> 0x00 and carry to hours; hours wrap 0x23 -> 0x00.
  - A low BCD digit of 9 rolls to 0 and carries to the high digit.
  - Registers 3..15 are plain storage.
- Write/tick collision: a write to reg0..2 in the same cycle as a tick overrides that register.
  - The carry into higher registers still applies from the pre-write value.
- Address persistence: cur_addr persists across transactions; a data phase with no preceding address phase uses the previous address.

Test Plan:
- Reset: hold rst_n = 0 -> all regs 0x00, ad high-Z, wr_evt = 0; read reg0 -> 0x00.
- Write then read: addr 0x05, write 0xA5, read addr 0x05 -> ad = 0xA5, stable until rd_n rises; wr_evt = 1 for one cycle.
- Seconds rollover: preload reg0 = 0x59, reg1 = 0x59, reg2 = 0x23, then one tick -> all three read 0x00.
- BCD carry: reg0 = 0x09, one tick -> 0x10; reg0 = 0x19 plus a write of 0x30 in the same cycle -> 0x30.
- Out-of-range: addr 0x20, write 0x77 -> no register changes and no wr_evt; read -> 0xFF.
- Aborted read: rd_n low for 1 clk (< DRIVE_DLY + sync) -> ad never driven; apply rst_n low during DRIVE -> ad released immediately.
